// File: rtl/wb_stage.sv
// RV32I write-back stage: MEM/WB register, load-data extraction and result select.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module wb_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 64
) (
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              valid_i,
   input  logic              RegWrite_i,
   input  logic [1:0]        wb_sel_i,
   input  logic [2:0]        funct3_i,
   input  logic [4:0]        rd_addr_i,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic [DATA_W-1:0] pc_plus4_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              valid_o,
   output logic              RegWrite_o,
   output logic [4:0]        rd_addr_o,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              load_misalign_o,
   output logic [CNT_W-1:0]  instret_o
);

   localparam logic [1:0] SEL_ALU = 2'b00, SEL_LD = 2'b01, SEL_PC4 = 2'b10;

   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic [1:0]        wb_sel;
      logic [2:0]        funct3;
      logic [4:0]        rd;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] pc4;
      logic [DATA_W-1:0] rdata;
   } wb_reg_t;

   wb_reg_t r;

   // A flush only kills the slot; the remaining fields keep their old values.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r <= '0;
      end else if (flush_i) begin
         r.valid     <= 1'b0;
         r.reg_write <= 1'b0;
      end else if (!stall_i) begin
         r.valid     <= valid_i;
         r.reg_write <= RegWrite_i;
         r.wb_sel    <= wb_sel_i;
         r.funct3    <= funct3_i;
         r.rd        <= rd_addr_i;
         r.alu       <= alu_result_i;
         r.pc4       <= pc_plus4_i;
         r.rdata     <= mem_rdata_i;
      end
   end

   logic [1:0]        off;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [DATA_W-1:0] result;
   logic              misalign;
   logic              reserved;

   assign off     = r.alu[1:0];
   assign ld_byte = r.rdata[{off, 3'b000} +: 8];
   assign ld_half = off[1] ? r.rdata[31:16] : r.rdata[15:0];

   always_comb begin
      result   = '0;
      misalign = 1'b0;
      reserved = 1'b0;
      unique case (r.wb_sel)
         SEL_ALU: result = r.alu;
         SEL_PC4: result = r.pc4;
         SEL_LD: begin
            unique case (r.funct3)
               3'b000: result = {{24{ld_byte[7]}}, ld_byte};
               3'b100: result = {24'd0, ld_byte};
               3'b001: begin
                  misalign = off[0];
                  result   = {{16{ld_half[15]}}, ld_half};
               end
               3'b101: begin
                  misalign = off[0];
                  result   = {16'd0, ld_half};
               end
               3'b010: begin
                  misalign = (off != 2'b00);
                  result   = r.rdata;
               end
               default: reserved = 1'b1;
            endcase
         end
         default: reserved = 1'b1;
      endcase
      // Faulting or reserved loads never leak data toward the register file.
      if (misalign || reserved) result = '0;
   end

   assign valid_o         = r.valid;
   assign rd_addr_o       = r.rd;
   assign rd_data_o       = result;
   assign load_misalign_o = r.valid & misalign;
   assign RegWrite_o      = r.valid & r.reg_write & (r.rd != 5'd0) & ~misalign & ~reserved;

`ifdef WB_INSTRET_EN
   logic [CNT_W-1:0] instret_q;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n)
         instret_q <= '0;
      else if (valid_o && !stall_i && !load_misalign_o)
         instret_q <= instret_q + CNT_W'(1);
   end

   assign instret_o = instret_q;
`else
   assign instret_o = '0;
`endif

endmodule
